// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 pooling window scheduler.
package pool_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef logic signed [15:0] pix_t;

  localparam int PIX_W = $bits(pix_t);
  localparam int TL = 0;
  localparam int TR = 1;
  localparam int BL = 2;
  localparam int BR = 3;

  // Counter width that stays >= 1 bit for degenerate sizes.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// One-row pixel store: synchronous write, two combinational read ports.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int FM_DEPTH = 64
) (
  input  logic                               clk,
  input  logic                               i_we,
  input  logic [cw(DEPTH)-1:0]               i_waddr,
  input  logic [FM_DEPTH-1:0][PIX_W-1:0]     i_wdata,
  input  logic [cw(DEPTH)-1:0]               i_raddr0,
  input  logic [cw(DEPTH)-1:0]               i_raddr1,
  output logic [FM_DEPTH-1:0][PIX_W-1:0]     o_rdata0,
  output logic [FM_DEPTH-1:0][PIX_W-1:0]     o_rdata1
);
  logic [FM_DEPTH-1:0][PIX_W-1:0] r_mem [DEPTH];

  // Contents need no reset: every entry is rewritten on an even row before it is read.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];
endmodule

// File: rtl/pool_win_ctrl.sv
// Raster pixel stream -> non-overlapping 2x2 windows for the average-pooling stage,
// with output coordinate tagging that tracks the stage's one-cycle register.
module pool_win_ctrl
  import pool_pkg::*;
#(
  parameter int FM_DEPTH  = 64,
  parameter int FM_WIDTH  = 32,
  parameter int FM_HEIGHT = 32
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [FM_DEPTH-1:0][PIX_W-1:0] in_data,
  output logic                                 win_valid,
  output logic signed [3:0][FM_DEPTH-1:0][PIX_W-1:0] win_data,
  output logic                                 out_valid,
  output logic [cw(FM_HEIGHT/2)-1:0]           out_row,
  output logic [cw(FM_WIDTH/2)-1:0]            out_col,
  output logic                                 busy,
  output logic                                 done
);
  localparam int CW  = cw(FM_WIDTH);
  localparam int RW  = cw(FM_HEIGHT);
  localparam int ORW = cw(FM_HEIGHT/2);
  localparam int OCW = cw(FM_WIDTH/2);

  if (FM_WIDTH < 2 || (FM_WIDTH % 2) != 0) begin : g_chk_w
    $fatal(1, "pool_win_ctrl: FM_WIDTH must be even and >= 2");
  end
  if (FM_HEIGHT < 2 || (FM_HEIGHT % 2) != 0) begin : g_chk_h
    $fatal(1, "pool_win_ctrl: FM_HEIGHT must be even and >= 2");
  end

  state_t r_state, w_next;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col_m1;
  logic          w_acc, w_col_last, w_row_last, w_win, w_lb_we;
  logic [FM_DEPTH-1:0][PIX_W-1:0] r_left, w_lb_tl, w_lb_tr;
  logic [3:0][FM_DEPTH-1:0][PIX_W-1:0] r_win;
  logic          r_win_valid, r_out_valid;
  logic [ORW-1:0] r_win_row, r_out_row;
  logic [OCW-1:0] r_win_col, r_out_col;

  assign w_acc      = in_valid && in_ready;
  assign w_col_last = (r_col == CW'(FM_WIDTH - 1));
  assign w_row_last = (r_row == RW'(FM_HEIGHT - 1));
  assign w_win      = w_acc && r_row[0] && r_col[0];
  assign w_lb_we    = w_acc && !r_row[0];
  assign w_col_m1   = r_col - 1'b1;

  pool_line_buf #(.DEPTH(FM_WIDTH), .FM_DEPTH(FM_DEPTH)) u_lb (
    .clk      (clk),
    .i_we     (w_lb_we),
    .i_waddr  (r_col),
    .i_wdata  (in_data),
    .i_raddr0 (w_col_m1),
    .i_raddr1 (r_col),
    .o_rdata0 (w_lb_tl),
    .o_rdata1 (w_lb_tr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // The last window's out_valid is the only one that can land in DRAIN,
  // so it alone marks frame completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_acc && w_col_last && w_row_last) w_next = DRAIN;
      DRAIN:   if (r_out_valid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      RUN:   begin in_ready = 1'b1; busy = 1'b1; end
      DRAIN: begin busy = 1'b1; done = r_out_valid; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == IDLE && start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_left      <= '0;
      r_win       <= '0;
      r_win_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else begin
      r_win_valid <= w_win;
      r_out_valid <= r_win_valid;
      if (w_acc && r_row[0] && !r_col[0]) r_left <= in_data;
      if (w_win) begin
        r_win[TL] <= w_lb_tl;
        r_win[TR] <= w_lb_tr;
        r_win[BL] <= r_left;
        r_win[BR] <= in_data;
        r_win_row <= ORW'(r_row >> 1);
        r_win_col <= OCW'(r_col >> 1);
      end
      // Coordinates follow the window through the pooling register stage.
      if (r_win_valid) begin
        r_out_row <= r_win_row;
        r_out_col <= r_win_col;
      end
    end
  end

  assign win_valid = r_win_valid;
  assign win_data  = r_win;
  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
endmodule

// File: tb/tb_pool_win_ctrl.sv
// Directed bench for pool_win_ctrl on a 4x4x2 frame with a window scoreboard
// and a behavioural 2x2 average-pooling stage.
module tb_pool_win_ctrl;
  logic clk, rstn, start, in_valid, in_ready;
  logic signed [1:0][15:0] in_data;
  logic win_valid, out_valid, busy, done;
  logic signed [3:0][1:0][15:0] win_data;
  logic [0:0] out_row, out_col;

  pool_win_ctrl #(.FM_DEPTH(2), .FM_WIDTH(4), .FM_HEIGHT(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .win_valid(win_valid), .win_data(win_data), .out_valid(out_valid),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] win;
    int           row;
    int           col;
    logic [31:0]  pool;
  } exp_t;

  exp_t wq[$];
  exp_t cq[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_e = 0;
  int done_cnt = 0;
  logic prev_wv = 1'b0;
  logic [31:0] pm = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int mode, input int r, input int c, input int ch);
    if (mode == 0) return 16'(r*4 + c);
    if (mode == 1) return 16'(100 + r*4 + c);
    if (r < 2 && c < 2) begin
      if (ch == 0) return 16'h8000;
      return (r == 1 && c == 1) ? 16'hFFFF : 16'h7FFF;
    end
    return 16'(r*4 + c);
  endfunction

  function automatic logic [1:0][15:0] px(input int mode, input int r, input int c);
    logic [1:0][15:0] p;
    p[0] = mk(mode, r, c, 0);
    p[1] = mk(mode, r, c, 1);
    return p;
  endfunction

  function automatic logic [15:0] avg(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c, input logic [15:0] d);
    logic signed [17:0] s;
    s = 18'(signed'(a)) + 18'(signed'(b)) + 18'(signed'(c)) + 18'(signed'(d));
    s = s >>> 2;
    return s[15:0];
  endfunction

  task automatic push_win(input int mode, input int r, input int c);
    exp_t e;
    logic [3:0][1:0][15:0] w;
    w[0] = px(mode, r-1, c-1);
    w[1] = px(mode, r-1, c);
    w[2] = px(mode, r, c-1);
    w[3] = px(mode, r, c);
    e.win = w;
    e.row = r >> 1;
    e.col = c >> 1;
    for (int ch = 0; ch < 2; ch++)
      e.pool[ch*16 +: 16] = avg(w[0][ch], w[1][ch], w[2][ch], w[3][ch]);
    wq.push_back(e);
  endtask

  // Scoreboard side plus a model of the pooling stage's one-cycle register.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      prev_wv = 1'b0;
    end else begin
      if (win_valid) begin
        chk("win_back2back", prev_wv, 0);
        chk("win_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("win_data", win_data, e.win);
          cq.push_back(e);
        end
        for (int ch = 0; ch < 2; ch++)
          pm[ch*16 +: 16] = avg(win_data[0][ch], win_data[1][ch], win_data[2][ch], win_data[3][ch]);
      end
      prev_wv = win_valid;
      if (out_valid) begin
        chk("out_expected", cq.size() != 0, 1);
        if (cq.size() != 0) begin
          e = cq.pop_front();
          chk("out_row", out_row, e.row);
          chk("out_col", out_col, e.col);
          chk("pool_result", pm, e.pool);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic send_pix(input int mode, input int r, input int c, input int gap, input bit st);
    bit acc;
    int g;
    acc = 1'b0;
    g = 0;
    start = st;
    while (!acc) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = px(mode, r, c);
      acc = in_valid && in_ready;
      if (acc && (r % 2) == 1 && (c % 2) == 1) push_win(mode, r, c);
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) last_e = cyc;
      g++;
      if (!acc && g > 100) begin
        bad++;
        $display("FAIL accept_timeout observed=no_accept expected=accept r=%0d c=%0d", r, c);
        $fatal(1, "beat never accepted");
      end
    end
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_win_valid"}, win_valid, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_win_data"}, win_data, 0);
    chk({pfx, "_out_row"}, out_row, 0);
    chk({pfx, "_out_col"}, out_col, 0);
  endtask

  task automatic run_frame(input int mode, input int gap, input bit smid, input bit sdrain, input int nb);
    bit got;
    int k;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = px(mode, 0, 0);
    chk("start_no_accept", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    chk("start_latency", in_ready, 1);
    k = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (k < nb) send_pix(mode, r, c, gap, smid && r == 2 && c == 0);
        k++;
      end
    in_valid = 1'b0;
    if (nb < 16) return;
    chk("in_ready_drop", in_ready, 0);
    if (sdrain) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("done_time", cyc, last_e + 1);
      chk("busy_at_done", busy, 1);
    end
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 0, 1'b0, 1'b0, 16);
    run_frame(1, 0, 1'b0, 1'b0, 16);
    run_frame(0, 50, 1'b1, 1'b1, 16);

    run_frame(0, 0, 1'b0, 1'b0, 6);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    reset_checks("midreset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_frame(0, 0, 1'b0, 1'b0, 16);

    run_frame(2, 0, 1'b0, 1'b0, 16);

    repeat (6) @(posedge clk);
    #1;
    chk("done_count", done_cnt, 5);
    chk("win_queue_empty", wq.size(), 0);
    chk("out_queue_empty", cq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pool_win_ctrl.md
# pool_win_ctrl

Window scheduler in front of the 2x2 average-pooling stage. Accepts a raster-order pixel stream (all FM_DEPTH channels per beat) for one feature map. Buffers one row, assembles non-overlapping 2x2 windows, and drives the pooling stage's `data_in_valid` and `pooling_in`. Tracks the pooling stage's one-cycle register latency and reports the output coordinates and end of frame.

## Interface
Parameters:
- FM_DEPTH, 64, channels per pixel.
- FM_WIDTH, 32, pixels per row; must be even and >= 2.
- FM_HEIGHT, 32, rows per frame; must be even and >= 2.

Ports:
- clk  in  1  clock. Single clock domain.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame start pulse. Honoured only in IDLE.
- in_valid  in  1  pixel beat valid.
- in_ready  out  1  pixel beat accepted when `in_valid && in_ready`.
- in_data  in  signed 16 x [FM_DEPTH]  pixel, all channels.
- win_valid  out  1  drives the pooling stage's `data_in_valid`.
- win_data  out  signed 16 x [FM_DEPTH][4]  drives `pooling_in`. Index [0]=top-left, [1]=top-right, [2]=bottom-left, [3]=bottom-right.
- out_valid  out  1  the pooled result is valid on the pooling stage's output this cycle.
- out_row  out  $clog2(FM_HEIGHT/2)  row coordinate of the result tagged by out_valid.
- out_col  out  $clog2(FM_WIDTH/2)  column coordinate of the result tagged by out_valid.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the frame is complete.

## Operation
State machine: IDLE -> RUN -> DRAIN -> IDLE.

- **IDLE**
  - in_ready=0.
  - `start` clears col/row counters and moves to RUN.
- **RUN**
  - in_ready=1. No backpressure from downstream; the pooling stage never stalls.
  - Each accepted beat advances col 0..FM_WIDTH-1. At wrap, col=0 and row increments.
  - Even row: the beat is written to line-buffer entry [col].
  - Odd row, even col: the beat is held in the left register.
  - Odd row, odd col: a window is formed:
    - [0] = linebuf[col-1]
    - [1] = linebuf[col]
    - [2] = left register
    - [3] = in_data
  - The window is registered into win_data and win_valid pulses the next cycle.
  - Accepting pixel (FM_HEIGHT-1, FM_WIDTH-1) moves to DRAIN; in_ready drops the following cycle.
- **DRAIN**
  - Waits until the last out_valid has been issued.
  - Pulses `done` in the same cycle as that last out_valid, then returns to IDLE.
- **Start handling:** `start` in RUN or DRAIN is ignored. `start` in the same cycle as an `in_valid` beat while in IDLE: the beat is not accepted (in_ready=0).
- **Data path:** no arithmetic. Data passes unchanged.
- **win_data hold:** win_data holds its last window while win_valid=0. The pooling stage samples it only on valid.
- **Coordinates:** out_row = row>>1 and out_col = col>>1 of the window's bottom-right pixel, delayed to align with out_valid.

## Timing
- **Reset values:** win_valid, out_valid, busy, done, in_ready = 0. win_data, out_row, out_col = 0. State = IDLE. Counters = 0. Line buffer contents don't-care.
- **Start latency:** start at cycle t -> in_ready=1 at t+1.
- **Window latency:** bottom-right beat accepted at cycle t -> win_valid=1 at t+1 -> out_valid=1 at t+2.
- **Output rate:** win_valid never fires on consecutive cycles; windows are at least 2 accepted beats apart.
- **Frame end:** done fires at t+2, where t is the cycle the last beat is accepted. busy falls at t+3.
- **Gaps:** in_valid gaps stall counters only; no state is lost.
- **Reset mid-frame:** returns immediately to IDLE with reset values. The partial frame is discarded. No done pulse.

## Structure
- **Shared package `pool_pkg`:**
  - state enum {IDLE, RUN, DRAIN}
  - `pix_t` (signed 16-bit)
  - window index constants TL=0, TR=1, BL=2, BR=3
- **Sub-module `pool_line_buf`:**
  - FM_WIDTH x (FM_DEPTH*16) register array.
  - Synchronous write with enable.
  - Two combinational read ports, addresses col-1 and col.
- **Elaboration checks:** fatal error if FM_WIDTH or FM_HEIGHT is odd or < 2.

## Test plan
- **Basic 4x4 frame** (FM_DEPTH=2, FM_WIDTH=4, FM_HEIGHT=4), continuous in_valid, pixel value = row*4+col on both channels:
  - 4 win_valid pulses.
  - First win_data = {0,1,4,5}; last = {10,11,14,15}.
  - out_(row,col) = (0,0),(0,1),(1,0),(1,1).
  - done at last-accept+2.
- **Random in_valid gaps** (~50% duty) on the same frame: identical window contents and order; no win_valid without a new bottom-right beat.
- **Start while busy:** pulse start mid-RUN and in DRAIN. No counter reset, no extra done; exactly one done per frame.
- **Reset mid-frame:** assert rstn=0 after 6 beats. All outputs 0 next cycle. A new start with a fresh frame produces correct first window {0,1,4,5}.
- **Back-to-back frames:** start issued the cycle after done. The second frame's windows are correct and do not mix in first-frame line-buffer data.
- **Sign and pooling integration** with the pooling stage attached: window {-32768,-32768,-32768,-32768} gives -32768; {32767,32767,32767,-1} gives 24575, sampled on out_valid.
